// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path: FSM state encoding,
// display sample width and the audio-to-display sample conversion.
package wave_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } capture_state_t;

    localparam int DISP_SAMPLE_W = 8;

    // Converts the top byte of a signed sample to offset binary by flipping
    // the sign bit, so the most negative value lands at the bottom of the screen.
    function automatic logic [DISP_SAMPLE_W-1:0] to_display_sample(
        input logic [DISP_SAMPLE_W-1:0] msb_byte
    );
        return {~msb_byte[DISP_SAMPLE_W-1], msb_byte[DISP_SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/wave_capture_zero_cross_detect.sv
// Rising zero-crossing detector: remembers the last strobed sample and flags
// a negative-to-non-negative transition on the current strobe.
module zero_cross_detect #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    output logic [SAMPLE_W-1:0] prev,
    output logic                crossing
);

    logic [SAMPLE_W-1:0] prev_r;

    // Track every strobed sample regardless of the capture state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= {SAMPLE_W{1'b0}};
        end else if (new_sample_ready) begin
            prev_r <= new_sample_in;
        end else begin
            prev_r <= prev_r;
        end
    end

    // A crossing is only meaningful on a strobe.
    always_comb begin
        crossing = 1'b0;
        if (new_sample_ready && prev_r[SAMPLE_W-1] && !new_sample_in[SAMPLE_W-1]) begin
            crossing = 1'b1;
        end else begin
            crossing = 1'b0;
        end
    end

    assign prev = prev_r;

endmodule

// File: rtl/wave_capture.sv
// Waveform capture stage: arms on a rising zero crossing, writes one screen
// of display samples into the inactive RAM half, then flips read_index once
// the display is idle.
// Optional feature macro: WAVE_CAPTURE_DECIMATE_EN (keep one strobe in
// 2^DECIM_LOG2 after the crossing sample).
module wave_capture
    import wave_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int NUM_SAMPLES = 128,
    parameter int DECIM_LOG2  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_sample_ready,
    input  logic [SAMPLE_W-1:0]            new_sample_in,
    input  logic                           wave_display_idle,
    output logic [$clog2(NUM_SAMPLES):0]   write_address,
    output logic [DISP_SAMPLE_W-1:0]       write_sample,
    output logic                           write_enable,
    output logic                           read_index
);

    localparam int IDX_W = $clog2(NUM_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    capture_state_t           state_r;
    logic [IDX_W-1:0]         index_r;
    logic                     read_index_r;
    logic                     write_enable_r;
    logic [IDX_W:0]           write_address_r;
    logic [DISP_SAMPLE_W-1:0] write_sample_r;

    logic                     crossing_s;
    logic                     accept_s;
    logic [SAMPLE_W-1:0]      prev_s;
    logic [DISP_SAMPLE_W-1:0] disp_s;

    zero_cross_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_zero_cross_detect (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .prev             (prev_s),
        .crossing         (crossing_s)
    );

    assign disp_s = to_display_sample(new_sample_in[SAMPLE_W-1 -: DISP_SAMPLE_W]);

`ifdef WAVE_CAPTURE_DECIMATE_EN
    logic [DECIM_LOG2-1:0] skip_r;

    // Skip counter: held at zero while armed so every capture starts fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_r <= {DECIM_LOG2{1'b0}};
        end else if (state_r == ARMED) begin
            skip_r <= {DECIM_LOG2{1'b0}};
        end else if ((state_r == ACTIVE) && new_sample_ready) begin
            skip_r <= skip_r + DECIM_LOG2'(1);
        end else begin
            skip_r <= skip_r;
        end
    end

    // Only the last strobe of each decimation group is kept.
    always_comb begin
        accept_s = 1'b0;
        if (new_sample_ready && (skip_r == {DECIM_LOG2{1'b1}})) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end
`else
    // Without decimation every strobe in ACTIVE is kept.
    always_comb begin
        accept_s = 1'b0;
        if (new_sample_ready) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end
`endif

    // Capture FSM with registered RAM write port and display half select.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ARMED;
            index_r         <= {IDX_W{1'b0}};
            read_index_r    <= 1'b0;
            write_enable_r  <= 1'b0;
            write_address_r <= {(IDX_W+1){1'b0}};
            write_sample_r  <= {DISP_SAMPLE_W{1'b0}};
        end else begin
            write_enable_r <= 1'b0;
            case (state_r)
                ARMED: begin
                    if (crossing_s) begin
                        write_enable_r  <= 1'b1;
                        write_address_r <= {~read_index_r, {IDX_W{1'b0}}};
                        write_sample_r  <= disp_s;
                        index_r         <= IDX_W'(1);
                        state_r         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept_s) begin
                        write_enable_r  <= 1'b1;
                        write_address_r <= {~read_index_r, index_r};
                        write_sample_r  <= disp_s;
                        if (index_r == LAST_IDX) begin
                            index_r <= {IDX_W{1'b0}};
                            state_r <= WAIT;
                        end else begin
                            index_r <= index_r + IDX_W'(1);
                        end
                    end
                end
                WAIT: begin
                    // Strobes here are dropped; the detector still tracks them.
                    if (wave_display_idle) begin
                        read_index_r <= ~read_index_r;
                        state_r      <= ARMED;
                    end
                end
                default: begin
                    state_r <= ARMED;
                    index_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign write_address = write_address_r;
    assign write_sample  = write_sample_r;
    assign write_enable  = write_enable_r;
    assign read_index    = read_index_r;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: directed test-plan sequences followed
// by randomized traffic, all compared cycle by cycle with a behavioural model.
module tb_wave_capture;
    import wave_pkg::*;

    localparam int SAMPLE_W    = 16;
    localparam int NUM_SAMPLES = 128;
    localparam int DECIM_LOG2  = 2;
    localparam int AW          = $clog2(NUM_SAMPLES) + 1;
`ifdef WAVE_CAPTURE_DECIMATE_EN
    localparam int DEC = 1 << DECIM_LOG2;
`else
    localparam int DEC = 1;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                new_sample_ready = 1'b0;
    logic [SAMPLE_W-1:0] new_sample_in = '0;
    logic                wave_display_idle = 1'b0;
    logic [AW-1:0]       write_address;
    logic [7:0]          write_sample;
    logic                write_enable;
    logic                read_index;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: plain counters describing the capture progress.
    logic [SAMPLE_W-1:0] m_prev;
    bit                  m_capturing, m_waiting, m_read;
    int                  m_count, m_strobes;
    logic                exp_we;
    logic [AW-1:0]       exp_addr;
    logic [7:0]          exp_data;

    wave_capture #(
        .SAMPLE_W    (SAMPLE_W),
        .NUM_SAMPLES (NUM_SAMPLES),
        .DECIM_LOG2  (DECIM_LOG2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_sample      (write_sample),
        .write_enable      (write_enable),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock given the inputs presented this cycle.
    task automatic model_step(input bit rst, input bit stb, input logic [SAMPLE_W-1:0] s, input bit idle);
        logic [7:0] top;
        top = s[SAMPLE_W-1 -: 8];
        if (rst) begin
            m_prev = '0; m_capturing = 0; m_waiting = 0; m_read = 0;
            m_count = 0; m_strobes = 0;
            exp_we = 1'b0; exp_addr = '0; exp_data = 8'h00;
            return;
        end
        exp_we = 1'b0;
        if (m_waiting) begin
            if (idle) begin
                m_read = !m_read;
                m_waiting = 0;
            end
        end else if (m_capturing) begin
            if (stb) begin
                m_strobes++;
                if (m_strobes % DEC == 0) begin
                    exp_we = 1'b1;
                    exp_addr = AW'((m_read ? 0 : NUM_SAMPLES) + m_count);
                    exp_data = to_display_sample(top);
                    m_count++;
                    if (m_count == NUM_SAMPLES) begin
                        m_capturing = 0; m_waiting = 1; m_count = 0;
                    end
                end
            end
        end else if (stb && m_prev[SAMPLE_W-1] && !s[SAMPLE_W-1]) begin
            exp_we = 1'b1;
            exp_addr = AW'(m_read ? 0 : NUM_SAMPLES);
            exp_data = to_display_sample(top);
            m_capturing = 1; m_count = 1; m_strobes = 0;
        end
        if (stb) m_prev = s;
    endtask

    // One clock: apply inputs, update the model, then compare after the edge.
    task automatic step(input bit rst, input bit stb, input logic [SAMPLE_W-1:0] s, input bit idle);
        reset = rst; new_sample_ready = stb; new_sample_in = s; wave_display_idle = idle;
        model_step(rst, stb, s, idle);
        @(posedge clk);
        #1;
        check_eq("write_enable", {31'd0, write_enable}, {31'd0, exp_we});
        check_eq("write_address", 32'(write_address), 32'(exp_addr));
        check_eq("write_sample", {24'd0, write_sample}, {24'd0, exp_data});
        check_eq("read_index", {31'd0, read_index}, {31'd0, m_read});
    endtask

    initial begin
        m_prev = '0; m_capturing = 0; m_waiting = 0; m_read = 0;
        m_count = 0; m_strobes = 0;
        exp_we = 1'b0; exp_addr = '0; exp_data = 8'h00;

        // Reset state.
        step(1, 0, 16'h0000, 0);
        step(1, 0, 16'h0000, 0);

        // No negative-to-positive crossing: no writes.
        step(0, 1, 16'h0100, 0);
        step(0, 1, 16'h0200, 0);
        step(0, 0, 16'h0000, 0);

        // Crossing: first write at 0x80 with data 0x81.
        step(0, 1, 16'hF000, 0);
        step(0, 1, 16'h0100, 0);
        check_eq("first_addr", 32'(write_address), 32'h80);
        check_eq("first_data", {24'd0, write_sample}, 32'h81);

        // Back-to-back strobes fill the half, then WAIT ignores strobes.
        for (int i = 0; i < (NUM_SAMPLES - 1) * DEC; i++) step(0, 1, 16'h7FFF, 0);
        check_eq("last_addr", 32'(write_address), 32'hFF);
        for (int i = 0; i < 4; i++) step(0, 1, 16'h8000 | 16'(i), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 16'h0000, 0);

        // Idle pulse with a simultaneous crossing strobe: toggle, no write.
        step(0, 1, 16'h0100, 1);
        check_eq("read_index_flip", {31'd0, read_index}, 32'd1);

        // Second capture writes into the lower half; decimation pattern 1,2,3...
        step(0, 1, 16'hF000, 0);
        step(0, 1, 16'h0000, 0);
        for (int k = 1; k < 60; k++) step(0, 1, {k[7:0], 8'h00}, 0);

        // Abandon a capture with reset mid-way.
        step(0, 0, 16'h0000, 1);
        for (int i = 0; i < 300; i++) step(0, 1, 16'h0000, 1);
        step(0, 1, 16'hF000, 0);
        step(0, 1, 16'h0100, 0);
        for (int i = 0; i < 49 * DEC; i++) step(0, 1, 16'(i), 0);
        step(1, 1, 16'h1234, 0);
        check_eq("reset_we", {31'd0, write_enable}, 32'd0);
        check_eq("reset_ri", {31'd0, read_index}, 32'd0);
        step(0, 1, 16'hF000, 0);
        step(0, 1, 16'h0100, 0);
        check_eq("restart_addr", 32'(write_address), 32'h80);

        // Randomized traffic with back-to-back and sparse strobes.
        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0),
                 16'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
